// File: rtl/mult_pkg.sv
`default_nettype none
// mult_pkg: shared state encoding, default operand widths and latency for the shift-add multiplier.
// Revision: 1.0
package mult_pkg;

  localparam int A_W_DEF = 4;
  localparam int B_W_DEF = 3;
  localparam int LAT     = B_W_DEF * (A_W_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// full_adder: 1-bit full adder cell, the sole arithmetic element of the serial multiplier.
// Revision: 1.0
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic sum,
  output logic carry
);

  assign sum   = A ^ B ^ C;
  assign carry = (A & B) | (A & C) | (B & C);

endmodule
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// shift_add_mult_ctrl: bit-serial shift-add unsigned multiplier around one full_adder, start/busy/done handshake.
// Revision: 1.0
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int BIW = $clog2(A_W);
  localparam int ITW = (B_W > 2) ? $clog2(B_W) : 1;
  localparam logic [BIW-1:0] c_BIT_LAST  = BIW'(A_W - 1);
  localparam logic [ITW-1:0] c_ITER_LAST = ITW'(B_W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [A_W-1:0]   r_mcand;
  logic [A_W-1:0]   r_acc_hi;
  logic [B_W-1:0]   r_mq;
  logic             r_cy;
  logic [BIW-1:0]   r_bit_idx;
  logic [ITW-1:0]   r_iter;
  logic [A_W+B_W-1:0] r_product;

  logic             w_accept;
  logic             w_bit_last;
  logic             w_iter_last;
  logic             w_fa_a;
  logic             w_fa_b;
  logic             w_fa_sum;
  logic             w_fa_carry;
  logic [A_W-1:0]   w_acc_sh;
  logic [B_W-1:0]   w_mq_sh;

  assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_bit_last  = (r_bit_idx == c_BIT_LAST);
  assign w_iter_last = (r_iter == c_ITER_LAST);

  // Multiplicand bit is gated by the current multiplier LSB, so a zero bit adds zero at fixed latency.
  assign w_fa_a = r_acc_hi[r_bit_idx];
  assign w_fa_b = r_mcand[r_bit_idx] & r_mq[0];

  full_adder u_fa (
    .A     (w_fa_a),
    .B     (w_fa_b),
    .C     (r_cy),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  assign w_acc_sh = {r_cy, r_acc_hi[A_W-1:1]};
  assign w_mq_sh  = {r_acc_hi[0], r_mq[B_W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_ADD;
      ST_ADD:   if (w_bit_last) w_state_nxt = ST_SHIFT;
      ST_SHIFT: w_state_nxt = w_iter_last ? ST_DONE : ST_ADD;
      ST_DONE:  w_state_nxt = start ? ST_ADD : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_mq      <= '0;
      r_cy      <= 1'b0;
      r_bit_idx <= '0;
      r_iter    <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand   <= a;
      r_mq      <= b;
      r_acc_hi  <= '0;
      r_cy      <= 1'b0;
      r_bit_idx <= '0;
      r_iter    <= '0;
    end else if (r_state == ST_ADD) begin
      r_acc_hi[r_bit_idx] <= w_fa_sum;
      r_cy                <= w_fa_carry;
      r_bit_idx           <= w_bit_last ? '0 : r_bit_idx + 1'b1;
    end else if (r_state == ST_SHIFT) begin
      r_cy     <= 1'b0;
      r_acc_hi <= w_acc_sh;
      r_mq     <= w_mq_sh;
      if (w_iter_last) r_product <= {w_acc_sh, w_mq_sh};
      else             r_iter    <= r_iter + 1'b1;
    end
  end

  assign busy    = (r_state == ST_ADD) || (r_state == ST_SHIFT);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// tb_shift_add_mult_ctrl: directed self-checking bench for the 4x3 shift-add multiplier.
// Revision: 1.0
module tb_shift_add_mult_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [2:0] b;
  logic       busy;
  logic       done;
  logic [6:0] product;

  int n_cmp = 0;
  int n_err = 0;

  shift_add_mult_ctrl #(.A_W(4), .B_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge, then counts busy samples until done; 0 ticks means done never came.
  task automatic run_op(input logic [3:0] ia, input logic [2:0] ib, output int nbusy, output int ticks);
    a = ia; b = ib; start = 1'b1;
    tick();
    start = 1'b0;
    nbusy = 0;
    ticks = 0;
    for (int g = 0; g < 40; g++) begin
      if (done) begin
        ticks = g + 1;
        break;
      end
      if (busy) nbusy++;
      tick();
    end
  endtask

  int nb, tk, cnt_done, gap;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_prod", 32'(product), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // 15 x 7
    run_op(4'd15, 3'd7, nb, tk);
    chk("t1_done_seen", 32'(tk != 0), 1);
    chk("t1_busy_cycles", 32'(nb), 15);
    chk("t1_busy_in_done", 32'(busy), 0);
    chk("t1_prod", 32'(product), 105);
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    tick(); tick();
    chk("t1_prod_hold", 32'(product), 105);
    chk("t1_idle_busy", 32'(busy), 0);

    // Exhaustive sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        run_op(4'(ia), 3'(ib), nb, tk);
        chk($sformatf("sw_prod_%0dx%0d", ia, ib), 32'(product), 32'(ia * ib));
        chk($sformatf("sw_lat_%0dx%0d", ia, ib), 32'(nb), 15);
        tick();
      end
    end

    // Start during busy is ignored
    a = 4'd9; b = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t3_busy_c7", 32'(busy), 1);
    a = 4'd3; b = 3'd6; start = 1'b1;
    tick();
    start = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        cnt_done++;
        chk("t3_prod", 32'(product), 45);
      end
      tick();
    end
    chk("t3_done_count", 32'(cnt_done), 1);
    chk("t3_prod_hold", 32'(product), 45);

    // Back-to-back start in DONE
    run_op(4'd12, 3'd3, nb, tk);
    chk("t4_done_seen", 32'(tk != 0), 1);
    chk("t4_prod1", 32'(product), 36);
    a = 4'd5; b = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_busy_next", 32'(busy), 1);
    chk("t4_done_next", 32'(done), 0);
    chk("t4_prod_kept", 32'(product), 36);
    gap = 0;
    for (int g = 1; g < 40; g++) begin
      if (done) begin
        gap = g;
        break;
      end
      tick();
    end
    chk("t4_gap", 32'(gap), 16);
    chk("t4_prod2", 32'(product), 35);
    tick();

    // Reset mid-operation
    a = 4'd15; b = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("t5_busy_c8", 32'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_prod", 32'(product), 0);
    cnt_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) cnt_done++;
      tick();
    end
    chk("t5_no_done", 32'(cnt_done), 0);
    run_op(4'd2, 3'd3, nb, tk);
    chk("t5_prod_new", 32'(product), 6);
    chk("t5_lat_new", 32'(nb), 15);
    tick();

    // Start held during reset
    rst_n = 1'b0; a = 4'd5; b = 3'd5; start = 1'b1;
    tick();
    chk("t6_busy_rst1", 32'(busy), 0);
    tick();
    chk("t6_busy_rst2", 32'(busy), 0);
    chk("t6_prod_rst", 32'(product), 0);
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_busy_after", 32'(busy), 1);
    tk = 0;
    for (int g = 0; g < 40; g++) begin
      if (done) begin
        tk = 1;
        break;
      end
      tick();
    end
    chk("t6_done_seen", 32'(tk), 1);
    chk("t6_prod", 32'(product), 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
